// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit for the RV32I datapath.
//
// Each instruction is sequenced through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// The unit shares one instruction/data memory and waits on mem_ready.
// It traps on an illegal opcode or on a memory timeout, and leaves TRAP on trap_clr.
//
// Optional feature: define MC_CU_INSTRET_EN to add the instret port.
// instret is a retired-instruction counter that increments on every PCWrite.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   opcode            instr[6:0] from the instruction register, sampled in DECODE
//   mem_ready         memory completes the current read/write this cycle
//   trap_clr          leave TRAP and restart at FETCH
//   ALUSrc, MemtoReg, Branch, Jump, Jalr, ALUOp
//                     class controls, registered on DECODE->EXEC
//   MemRead, MemWrite, RegWrite, IRWrite, PCWrite, instr_fetch
//                     state-gated strobes
//   state             FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   trap, trap_cause  trap flag; cause 01 = illegal opcode, 10 = memory timeout
//   instret           retired instruction count (MC_CU_INSTRET_EN only)
module mc_cu #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       trap_clr,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       Branch,
  output logic       Jump,
  output logic       Jalr,
  output logic [1:0] ALUOp,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       instr_fetch,
  output logic [2:0] state,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef MC_CU_INSTRET_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Last wait-count value before a timeout fires; unused when MEM_TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]      next_state;
  logic [TO_W-1:0] wait_cnt;
  logic            is_load;
  logic            is_store;
  logic            legal;
  logic            mem_wait;
  logic            timeout;
  logic            d_alusrc;
  logic            d_memtoreg;
  logic            d_branch;
  logic            d_jump;
  logic            d_jalr;
  logic            d_load;
  logic            d_store;
  logic [1:0]      d_aluop;

  always_comb begin
    d_alusrc   = 1'b0;
    d_memtoreg = 1'b0;
    d_branch   = 1'b0;
    d_jump     = 1'b0;
    d_jalr     = 1'b0;
    d_load     = 1'b0;
    d_store    = 1'b0;
    d_aluop    = 2'b00;
    legal      = 1'b1;
    case (opcode)
      OP_R:    d_aluop = 2'b10;
      OP_I:    begin d_alusrc = 1'b1; d_aluop = 2'b11; end
      OP_LD:   begin d_alusrc = 1'b1; d_memtoreg = 1'b1; d_load = 1'b1; end
      OP_ST:   begin d_alusrc = 1'b1; d_store = 1'b1; end
      OP_BR:   begin d_branch = 1'b1; d_aluop = 2'b01; end
      OP_JAL:  d_jump = 1'b1;
      OP_JALR: begin d_jalr = 1'b1; d_alusrc = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // A memory wait is any FETCH/MEM cycle without mem_ready.
  // mem_ready therefore always wins over the timeout.
  assign mem_wait = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == TO_LAST);

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    next_state = S_DECODE;
        else if (timeout) next_state = S_TRAP;
      end
      S_DECODE: next_state = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (Branch)                  next_state = S_FETCH;
        else if (is_load || is_store) next_state = S_MEM;
        else                          next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready)    next_state = is_load ? S_WB : S_FETCH;
        else if (timeout) next_state = S_TRAP;
      end
      S_WB:    next_state = S_FETCH;
      S_TRAP:  if (trap_clr) next_state = S_FETCH;
      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      ALUSrc     <= 1'b0;
      MemtoReg   <= 1'b0;
      Branch     <= 1'b0;
      Jump       <= 1'b0;
      Jalr       <= 1'b0;
      ALUOp      <= 2'b00;
      is_load    <= 1'b0;
      is_store   <= 1'b0;
      trap_cause <= 2'b00;
      wait_cnt   <= '0;
    end else begin
      state <= next_state;
      // Class controls only move on a legal decode.
      // An illegal opcode keeps the previous instruction's values.
      if (state == S_DECODE && legal) begin
        ALUSrc   <= d_alusrc;
        MemtoReg <= d_memtoreg;
        Branch   <= d_branch;
        Jump     <= d_jump;
        Jalr     <= d_jalr;
        ALUOp    <= d_aluop;
        is_load  <= d_load;
        is_store <= d_store;
      end
      if (state == S_DECODE && !legal)
        trap_cause <= 2'b01;
      else if (timeout)
        trap_cause <= 2'b10;
      else if (state == S_TRAP && trap_clr)
        trap_cause <= 2'b00;
      // Count only while waiting in the same state; saturate at all-ones.
      if (mem_wait && next_state == state) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + TO_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign instr_fetch = (state == S_FETCH);
  assign MemRead     = (state == S_FETCH) || (state == S_MEM && is_load);
  assign MemWrite    = (state == S_MEM) && is_store;
  assign RegWrite    = (state == S_WB);
  assign IRWrite     = (state == S_FETCH) && mem_ready;
  // Exactly one PC commit per retired instruction:
  // branch in EXEC, store on MEM completion, everything else in WB.
  assign PCWrite     = ((state == S_EXEC) && Branch) ||
                       ((state == S_MEM) && is_store && mem_ready) ||
                       (state == S_WB);
  assign trap        = (state == S_TRAP);

`ifdef MC_CU_INSTRET_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       instret <= '0;
    else if (PCWrite) instret <= instret + CNT_W'(1);
  end
`else
  // No retired-instruction counter in this build.
`endif

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: scoreboard bench for mc_cu.
// Stimulus pushes hand-computed per-cycle expectations into a queue.
// A negedge monitor pops and compares them against the DUT outputs.
module tb_mc_cu;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic       mem_ready = 1'b0;
  logic       trap_clr = 1'b0;
  logic       ALUSrc, MemtoReg, Branch, Jump, Jalr;
  logic [1:0] ALUOp;
  logic       MemRead, MemWrite, RegWrite, IRWrite, PCWrite, instr_fetch;
  logic [2:0] state;
  logic       trap;
  logic [1:0] trap_cause;
`ifdef MC_CU_INSTRET_EN
  logic [CNT_W-1:0] instret;
`endif

  mc_cu #(.MEM_TIMEOUT(4), .TO_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .trap_clr(trap_clr), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .Branch(Branch), .Jump(Jump), .Jalr(Jalr), .ALUOp(ALUOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .instr_fetch(instr_fetch),
    .state(state), .trap(trap), .trap_cause(trap_cause)
`ifdef MC_CU_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  // Class vector {ALUSrc, MemtoReg, Branch, Jump, Jalr, ALUOp[1:0]}
  localparam logic [6:0] C0  = 7'b0000000;
  localparam logic [6:0] CR  = 7'b0000010;
  localparam logic [6:0] CI  = 7'b1000011;
  localparam logic [6:0] CL  = 7'b1100000;
  localparam logic [6:0] CS  = 7'b1000000;
  localparam logic [6:0] CB  = 7'b0010001;
  localparam logic [6:0] CJ  = 7'b0001000;
  localparam logic [6:0] CJR = 7'b1000100;

  // Strobe vector {MemRead, MemWrite, RegWrite, IRWrite, PCWrite, instr_fetch, trap}
  localparam logic [6:0] F_WAIT  = 7'b1000010;
  localparam logic [6:0] F_RDY   = 7'b1001010;
  localparam logic [6:0] NONE    = 7'b0000000;
  localparam logic [6:0] WBS     = 7'b0010100;
  localparam logic [6:0] MRD     = 7'b1000000;
  localparam logic [6:0] MWR     = 7'b0100000;
  localparam logic [6:0] MWR_RDY = 7'b0100100;
  localparam logic [6:0] EXBR    = 7'b0000100;
  localparam logic [6:0] TRAPS   = 7'b0000001;

  typedef struct packed {
    logic [2:0]  st;
    logic [6:0]  cls;
    logic [6:0]  strb;
    logic [1:0]  cause;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ret_cnt = 0;
  int   cyc = 0;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic applyStimulus(input logic rn, input logic mr, input logic tc,
                               input logic [6:0] op, input logic [2:0] st,
                               input logic [6:0] cls, input logic [6:0] strb,
                               input logic [1:0] cause);
    exp_t e;
    rst_n     = rn;
    mem_ready = mr;
    trap_clr  = tc;
    opcode    = op;
    e.st    = st;
    e.cls   = cls;
    e.strb  = strb;
    e.cause = cause;
    e.ret   = 32'(ret_cnt);
    exp_q.push_back(e);
    if (strb[2]) ret_cnt++;
    if (!rn) ret_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [18:0] got;
    logic [18:0] want;
    got  = {state, ALUSrc, MemtoReg, Branch, Jump, Jalr, ALUOp,
            MemRead, MemWrite, RegWrite, IRWrite, PCWrite, instr_fetch, trap,
            trap_cause};
    want = {e.st, e.cls, e.strb, e.cause};
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL ctrl cycle %0d: got st=%0d cls=%b strb=%b cause=%b, want st=%0d cls=%b strb=%b cause=%b",
               cyc, got[18:16], got[15:9], got[8:2], got[1:0],
               e.st, e.cls, e.strb, e.cause);
    end
`ifdef MC_CU_INSTRET_EN
    total++;
    if (instret !== e.ret) begin
      bad++;
      $display("[TB] FAIL instret cycle %0d: got %0d, want %0d", cyc, instret, e.ret);
    end
`endif
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e);
      cyc++;
    end
  end

  initial begin
    $display("[TB] mc_cu scoreboard bench start");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // R-type, zero wait
    applyStimulus(1, 1, 0, OP_R, 3'd0, C0, F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_R, 3'd1, C0, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_R, 3'd2, CR, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_R, 3'd4, CR, WBS,   2'b00);
    // Load with three memory wait cycles
    applyStimulus(1, 1, 0, OP_LD, 3'd0, CR, F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_LD, 3'd1, CR, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_LD, 3'd2, CL, NONE,  2'b00);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, OP_LD, 3'd3, CL, MRD, 2'b00);
    applyStimulus(1, 1, 0, OP_LD, 3'd3, CL, MRD, 2'b00);
    applyStimulus(1, 1, 0, OP_LD, 3'd4, CL, WBS, 2'b00);
    // Store
    applyStimulus(1, 1, 0, OP_ST, 3'd0, CL, F_RDY,   2'b00);
    applyStimulus(1, 1, 0, OP_ST, 3'd1, CL, NONE,    2'b00);
    applyStimulus(1, 1, 0, OP_ST, 3'd2, CS, NONE,    2'b00);
    applyStimulus(1, 1, 0, OP_ST, 3'd3, CS, MWR_RDY, 2'b00);
    // Branch
    applyStimulus(1, 1, 0, OP_BR, 3'd0, CS, F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_BR, 3'd1, CS, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_BR, 3'd2, CB, EXBR,  2'b00);
    // I-type, JAL, JALR
    applyStimulus(1, 1, 0, OP_I, 3'd0, CB, F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_I, 3'd1, CB, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_I, 3'd2, CI, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_I, 3'd4, CI, WBS,   2'b00);
    applyStimulus(1, 1, 0, OP_JAL, 3'd0, CI, F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_JAL, 3'd1, CI, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_JAL, 3'd2, CJ, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_JAL, 3'd4, CJ, WBS,   2'b00);
    applyStimulus(1, 1, 0, OP_JALR, 3'd0, CJ,  F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_JALR, 3'd1, CJ,  NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_JALR, 3'd2, CJR, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_JALR, 3'd4, CJR, WBS,   2'b00);
    // Illegal opcode trap, then clear
    applyStimulus(1, 1, 0, OP_BAD, 3'd0, CJR, F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_BAD, 3'd1, CJR, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_BAD, 3'd7, CJR, TRAPS, 2'b01);
    applyStimulus(1, 1, 1, OP_BAD, 3'd7, CJR, TRAPS, 2'b01);
    // Fetch timeout after four wait cycles
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 0, OP_R, 3'd0, CJR, F_WAIT, 2'b00);
    applyStimulus(1, 0, 0, OP_R, 3'd7, CJR, TRAPS, 2'b10);
    applyStimulus(1, 0, 1, OP_R, 3'd7, CJR, TRAPS, 2'b10);
    // mem_ready on the fourth wait cycle beats the timeout
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, OP_ST, 3'd0, CJR, F_WAIT, 2'b00);
    applyStimulus(1, 1, 0, OP_ST, 3'd0, CJR, F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_ST, 3'd1, CJR, NONE,  2'b00);
    applyStimulus(1, 0, 0, OP_ST, 3'd2, CS,  NONE,  2'b00);
    applyStimulus(1, 0, 0, OP_ST, 3'd3, CS,  MWR,   2'b00);
    // Reset mid-store
    applyStimulus(0, 0, 0, OP_ST, 3'd3, CS, MWR, 2'b00);
    applyStimulus(1, 1, 0, OP_R, 3'd0, C0, F_RDY, 2'b00);
    applyStimulus(1, 1, 0, OP_R, 3'd1, C0, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_R, 3'd2, CR, NONE,  2'b00);
    applyStimulus(1, 1, 0, OP_R, 3'd4, CR, WBS,   2'b00);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
